// File: rtl/exe_forward_scheduler.sv
// Operand-forwarding scheduler for the EXE stage: tracks EXE/MEM destinations,
// registers next-cycle operand selects, raises load-use / no-forward stalls.
module exe_forward_scheduler #(
  parameter int REG_FILE_DEPTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en,
  input  logic                      id_valid,
  input  logic [REG_FILE_DEPTH-1:0] id_src1,
  input  logic [REG_FILE_DEPTH-1:0] id_src2,
  input  logic                      id_two_src,
  input  logic [REG_FILE_DEPTH-1:0] id_dst,
  input  logic                      id_wb_en,
  input  logic                      id_mem_read,
  input  logic                      flush,
  output logic                      hazard,
  output logic [1:0]                sel_src1,
  output logic [1:0]                sel_src2,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam logic [REG_FILE_DEPTH-1:0] PC_IDX = REG_FILE_DEPTH'(15);
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [REG_FILE_DEPTH-1:0] ex_dst_p1;
  logic                      ex_wb_en_p1;
  logic                      ex_mem_read_p1;
  logic [REG_FILE_DEPTH-1:0] mem_dst_p2;
  logic                      mem_wb_en_p2;

  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic any_ex, any_mem;
  logic accept;

  function automatic logic src_match(input logic [REG_FILE_DEPTH-1:0] src,
                                     input logic                      wb_en,
                                     input logic [REG_FILE_DEPTH-1:0] dst);
    return wb_en && (src != PC_IDX) && (src == dst);
  endfunction

  function automatic logic [1:0] pick_sel(input logic fwd,
                                          input logic m_ex,
                                          input logic m_mem);
    if (!fwd)  return SEL_RF;
    if (m_ex)  return SEL_MEM;
    if (m_mem) return SEL_WB;
    return SEL_RF;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  endfunction

  // ID stage (p0): compare sources against the EXE/MEM shadow state
  assign m1_ex   = src_match(id_src1, ex_wb_en_p1, ex_dst_p1);
  assign m2_ex   = id_two_src && src_match(id_src2, ex_wb_en_p1, ex_dst_p1);
  assign m1_mem  = src_match(id_src1, mem_wb_en_p2, mem_dst_p2);
  assign m2_mem  = id_two_src && src_match(id_src2, mem_wb_en_p2, mem_dst_p2);
  assign any_ex  = m1_ex || m2_ex;
  assign any_mem = m1_mem || m2_mem;

  always_comb begin
    hazard = 1'b0;
    if (id_valid && !flush) begin
      if (fwd_en) hazard = any_ex && ex_mem_read_p1;
      else        hazard = any_ex || any_mem;
    end
  end

  assign accept = id_valid && !flush && !hazard;

  // EXE (p1) / MEM (p2) boundary: shadow state, selects and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_dst_p1      <= '0;
      ex_wb_en_p1    <= 1'b0;
      ex_mem_read_p1 <= 1'b0;
      mem_dst_p2     <= '0;
      mem_wb_en_p2   <= 1'b0;
      sel_src1       <= SEL_RF;
      sel_src2       <= SEL_RF;
      stall_count    <= '0;
    end else begin
      mem_dst_p2   <= ex_dst_p1;
      mem_wb_en_p2 <= ex_wb_en_p1;
      if (accept) begin
        ex_dst_p1      <= id_dst;
        ex_wb_en_p1    <= id_wb_en;
        ex_mem_read_p1 <= id_mem_read;
        sel_src1       <= pick_sel(fwd_en, m1_ex, m1_mem);
        sel_src2       <= pick_sel(fwd_en, m2_ex, m2_mem);
      end else begin
        ex_dst_p1      <= '0;
        ex_wb_en_p1    <= 1'b0;
        ex_mem_read_p1 <= 1'b0;
        sel_src1       <= SEL_RF;
        sel_src2       <= SEL_RF;
      end
      if (hazard) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: doc/exe_forward_scheduler.md
# exe_forward_scheduler

Tracks the destinations of the instructions in flight in the EXE and MEM stages and decides, one cycle ahead, how the EXE stage sources its two ALU operands. It drives the 2-bit operand-source selects of the EXE stage's operand muxes. It raises the pipeline hazard/stall signal for load-use and no-forwarding conflicts and counts stall cycles for performance monitoring. It sits between the ID/EXE pipeline register and the EXE stage and owns a shadow copy of the EXE/MEM destination state.

## Interface
Parameters:
- REG_FILE_DEPTH, 4, width of a register index.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- fwd_en  input  1  1 enables forwarding; 0 means hazards resolve by stalling only.
- id_valid  input  1  ID stage holds a real instruction.
- id_src1  input  REG_FILE_DEPTH  Rn index of ID instruction.
- id_src2  input  REG_FILE_DEPTH  Rm/Rd-store index of ID instruction.
- id_two_src  input  1  id_src2 is a true source.
- id_dst  input  REG_FILE_DEPTH  destination of ID instruction.
- id_wb_en  input  1  ID instruction writes id_dst.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  taken branch; ID instruction is discarded this cycle.
- hazard  output  1  combinational stall request to PC/IF/ID registers.
- sel_src1  output  2  registered select for ALU operand 1.
- sel_src2  output  2  registered select for ALU operand 2.
- stall_count  output  CNT_WIDTH  saturating count of cycles with hazard=1.

Select encoding: 00 register-file value, 01 MEM-stage value, 10 WB-stage value, 11 unused (never driven).

## Operation
- Shadow state: ex_{dst,wb_en,mem_read} (instruction now in EXE), mem_{dst,wb_en} (instruction now in MEM).
- Register 15 never matches (PC read, never forwarded or stalled on).
- Match rule: src matches stage X iff X_wb_en=1 and src==X_dst; src2 considered only when id_two_src=1.
- hazard (combinational), only when id_valid=1 and flush=0:
  - fwd_en=1: 1 iff a source matches EXE and ex_mem_read=1 (load-use).
  - fwd_en=0: 1 iff a source matches EXE or MEM.
- Each rising edge, when not in reset:
  - mem_* <= ex_* (dst, wb_en).
  - If flush=1, hazard=1, or id_valid=0: ex_* <= bubble (wb_en=0, mem_read=0, dst=0); sel_src1/2 <= 00.
  - Else: ex_* <= id_*; each sel_srcN <= 01 if fwd_en and src matches EXE (non-load); else 10 if fwd_en and src matches MEM; else 00. The EXE match has priority over the MEM match.
  - stall_count increments when hazard=1; holds at all-ones.
- Writes performed by the WB stage are visible to ID register reads in the same cycle, so no third forwarding level exists.

## Timing
- Reset (rst=0, asynchronous): ex_*, mem_*, sel_src1, sel_src2, stall_count all 0. hazard is 0 because ex_wb_en and mem_wb_en are 0.
- Selects computed in the ID cycle and presented the following cycle, aligned with that instruction's EXE cycle.
- Load-use with fwd_en=1: exactly 1 stall cycle. A bubble enters EXE. The retried instruction then gets select 10.
- fwd_en=0: a dependence on EXE gives 2 stall cycles; a dependence on MEM gives 1.
- flush with a simultaneous hazard: flush wins, hazard=0, and the counter does not increment.
- A fwd_en change takes effect on the next ID decision; it has no retroactive effect on selects already registered.
- Reset deasserted mid-stream: the first post-reset instruction sees an empty pipeline.

## Test plan
- Back-to-back ALU: ID1 writes R3; the next ID reads src1=R3, fwd_en=1 -> hazard stays 0; sel_src1=01 during that instruction's EXE cycle.
- Distance-2 dependence: R4 written, one unrelated instruction between, then a reader with src2=R4 and two_src=1 -> sel_src2=10, no stall. With two_src=0 -> sel_src2=00.
- Load-use: LDR R5 followed by ADD using R5 -> hazard=1 for one cycle, bubble enters EXE, ADD gets sel=10, stall_count=1.
- fwd_en=0, dependent adjacent pair on R2 -> hazard=1 for 2 cycles, selects 00, stall_count=2.
- flush during a load-use conflict -> hazard=0, ex_wb_en=0 next cycle, stall_count unchanged. src=R15 matching an EXE dst of 15 -> no hazard, select 00.
- Assert rst=0 asynchronously mid-stall -> all outputs 0 immediately; saturation check: preload 16'hFFFF via forced hazards -> counter holds at 16'hFFFF.
